// File: rtl/branch_recovery_ctrl_if.sv
// branch_recovery_ctrl_if: groups every signal between the branch recovery
// controller and its neighbours (branch FU, ROB, rename map, fetch).
//   master : environment side; drives branch results, rob_head and restore_ack
//   slave  : controller side; drives flush, restore, redirect, checkpoint-free,
//            stall and error outputs
interface branch_recovery_ctrl_if #(
  parameter int unsigned ROB_TAG_W = 5,
  parameter int unsigned XLEN      = 32
);
  logic                 b_done;
  logic                 b_mispredict;
  logic                 b_hit;
  logic [ROB_TAG_W-1:0] b_rob_tag;
  logic [XLEN-1:0]      b_target_pc;
  logic [ROB_TAG_W-1:0] rob_head;
  logic                 restore_ack;

  logic                 flush_valid;
  logic [ROB_TAG_W-1:0] flush_tag;
  logic                 restore_req;
  logic [ROB_TAG_W-1:0] restore_tag;
  logic                 redirect_valid;
  logic [XLEN-1:0]      redirect_pc;
  logic                 ckpt_free_valid;
  logic [ROB_TAG_W-1:0] ckpt_free_tag;
  logic                 frontend_stall;
  logic                 recover_err;

  modport master (
    output b_done, b_mispredict, b_hit, b_rob_tag, b_target_pc, rob_head, restore_ack,
    input  flush_valid, flush_tag, restore_req, restore_tag, redirect_valid, redirect_pc,
           ckpt_free_valid, ckpt_free_tag, frontend_stall, recover_err
  );

  modport slave (
    input  b_done, b_mispredict, b_hit, b_rob_tag, b_target_pc, rob_head, restore_ack,
    output flush_valid, flush_tag, restore_req, restore_tag, redirect_valid, redirect_pc,
           ckpt_free_valid, ckpt_free_tag, frontend_stall, recover_err
  );
endinterface

// File: rtl/branch_recovery_ctrl.sv
// branch_recovery_ctrl: sequences branch misprediction recovery.
// Latches the oldest outstanding mispredict (tag, target PC) and steps
// FLUSH -> RESTORE -> REDIRECT, letting strictly older mispredicts restart the
// sequence. Correctly predicted branches release their checkpoint.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   io (slave) : branch FU inputs, rob_head, restore_ack in; flush, restore,
//                redirect, checkpoint-free pulses, frontend_stall, recover_err out
// Optional feature: define BRCTL_RESTORE_TIMEOUT_EN to build the RESTORE
// watchdog (TIMEOUT_CYCLES) and the sticky recover_err flag.
module branch_recovery_ctrl #(
  parameter int unsigned ROB_TAG_W      = 5,
  parameter int unsigned XLEN           = 32
`ifdef BRCTL_RESTORE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input logic                    clk,
  input logic                    reset,
  branch_recovery_ctrl_if.slave  io
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_FLUSH    = 2'd1;
  localparam logic [1:0] S_RESTORE  = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  logic [1:0]           state, state_next;
  logic [ROB_TAG_W-1:0] lat_tag, lat_tag_next;
  logic [XLEN-1:0]      lat_pc, lat_pc_next;

  logic                 flush_valid, flush_valid_next;
  logic [ROB_TAG_W-1:0] flush_tag, flush_tag_next;
  logic                 restore_req, restore_req_next;
  logic [ROB_TAG_W-1:0] restore_tag, restore_tag_next;
  logic                 redirect_valid, redirect_valid_next;
  logic [XLEN-1:0]      redirect_pc, redirect_pc_next;
  logic                 free_valid, free_valid_next;
  logic [ROB_TAG_W-1:0] free_tag, free_tag_next;
  logic                 stall, stall_next;

  logic                 mp, hit, older;

`ifdef BRCTL_RESTORE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             err, err_next;
`endif

  // Age relative to the ROB head; modular subtraction handles wrap.
  function automatic logic [ROB_TAG_W-1:0] age_of(input logic [ROB_TAG_W-1:0] tag,
                                                  input logic [ROB_TAG_W-1:0] head);
    age_of = tag - head;
  endfunction

  // Next-state, latch and registered-output decode.
  always_comb begin
    state_next    = state;
    lat_tag_next  = lat_tag;
    lat_pc_next   = lat_pc;
    free_valid_next = 1'b0;
    free_tag_next   = '0;
`ifdef BRCTL_RESTORE_TIMEOUT_EN
    cnt_next = '0;
    err_next = err;
`endif

    mp    = io.b_done & io.b_mispredict;
    hit   = io.b_done & io.b_hit;
    older = age_of(io.b_rob_tag, io.rob_head) < age_of(lat_tag, io.rob_head);

    case (state)
      S_IDLE: begin
        if (mp) begin
          lat_tag_next = io.b_rob_tag;
          lat_pc_next  = io.b_target_pc;
          state_next   = S_FLUSH;
        end else if (hit) begin
          free_valid_next = 1'b1;
          free_tag_next   = io.b_rob_tag;
        end
      end
      S_FLUSH:    state_next = S_RESTORE;
      S_RESTORE: begin
        if (io.restore_ack) begin
          state_next = S_REDIRECT;
        end
`ifdef BRCTL_RESTORE_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_next = S_REDIRECT;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
`endif
      end
      S_REDIRECT: state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase

    // A strictly older mispredict restarts recovery and wins over any pending
    // transition, so a redirect that would have been issued is never emitted.
    if (state != S_IDLE) begin
      if (mp && older) begin
        lat_tag_next = io.b_rob_tag;
        lat_pc_next  = io.b_target_pc;
        state_next   = S_FLUSH;
`ifdef BRCTL_RESTORE_TIMEOUT_EN
        cnt_next     = '0;
`endif
      end
      if (hit && older) begin
        free_valid_next = 1'b1;
        free_tag_next   = io.b_rob_tag;
      end
    end

    // Outputs follow the state being entered; tags/PC read zero when idle.
    flush_valid_next    = (state_next == S_FLUSH);
    flush_tag_next      = flush_valid_next ? lat_tag_next : '0;
    restore_req_next    = (state_next == S_RESTORE);
    restore_tag_next    = restore_req_next ? lat_tag_next : '0;
    redirect_valid_next = (state_next == S_REDIRECT);
    redirect_pc_next    = redirect_valid_next ? lat_pc_next : '0;
    stall_next          = (state_next != S_IDLE);
  end

  // State, latch and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      lat_tag        <= '0;
      lat_pc         <= '0;
      flush_valid    <= 1'b0;
      flush_tag      <= '0;
      restore_req    <= 1'b0;
      restore_tag    <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      free_valid     <= 1'b0;
      free_tag       <= '0;
      stall          <= 1'b0;
`ifdef BRCTL_RESTORE_TIMEOUT_EN
      cnt            <= '0;
      err            <= 1'b0;
`endif
    end else begin
      state          <= state_next;
      lat_tag        <= lat_tag_next;
      lat_pc         <= lat_pc_next;
      flush_valid    <= flush_valid_next;
      flush_tag      <= flush_tag_next;
      restore_req    <= restore_req_next;
      restore_tag    <= restore_tag_next;
      redirect_valid <= redirect_valid_next;
      redirect_pc    <= redirect_pc_next;
      free_valid     <= free_valid_next;
      free_tag       <= free_tag_next;
      stall          <= stall_next;
`ifdef BRCTL_RESTORE_TIMEOUT_EN
      cnt            <= cnt_next;
      err            <= err_next;
`endif
    end
  end

  assign io.flush_valid     = flush_valid;
  assign io.flush_tag       = flush_tag;
  assign io.restore_req     = restore_req;
  assign io.restore_tag     = restore_tag;
  assign io.redirect_valid  = redirect_valid;
  assign io.redirect_pc     = redirect_pc;
  assign io.ckpt_free_valid = free_valid;
  assign io.ckpt_free_tag   = free_tag;
  assign io.frontend_stall  = stall;
`ifdef BRCTL_RESTORE_TIMEOUT_EN
  assign io.recover_err     = err;
`else
  assign io.recover_err     = 1'b0;
`endif

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// tb_branch_recovery_ctrl: directed self-checking bench for branch_recovery_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each check sees the registered values of the current cycle.
module tb_branch_recovery_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic err_exp = 1'b0;

  always #5 clk = ~clk;

  branch_recovery_ctrl_if #(.ROB_TAG_W(5), .XLEN(32)) bus ();

  branch_recovery_ctrl #(.ROB_TAG_W(5), .XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(bus.b_mispredict && bus.b_hit))
        else $error("FAIL input_excl mispredict=%0b hit=%0b", bus.b_mispredict, bus.b_hit);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.b_done       = 1'b0;
    bus.b_mispredict = 1'b0;
    bus.b_hit        = 1'b0;
    bus.b_rob_tag    = '0;
    bus.b_target_pc  = '0;
    bus.restore_ack  = 1'b0;
  endtask

  task automatic mispredict(input logic [4:0] t, input logic [31:0] pc);
    bus.b_done       = 1'b1;
    bus.b_mispredict = 1'b1;
    bus.b_hit        = 1'b0;
    bus.b_rob_tag    = t;
    bus.b_target_pc  = pc;
  endtask

  task automatic hit(input logic [4:0] t);
    bus.b_done       = 1'b1;
    bus.b_mispredict = 1'b0;
    bus.b_hit        = 1'b1;
    bus.b_rob_tag    = t;
    bus.b_target_pc  = 32'h0;
  endtask

  task automatic expect_out(input string tag,
                            input logic fv, input logic [4:0] ft,
                            input logic rq, input logic [4:0] rt,
                            input logic rv, input logic [31:0] rp,
                            input logic cv, input logic [4:0] ct,
                            input logic st, input logic er);
    logic [52:0] obs, exp;
    obs = {bus.flush_valid, bus.flush_tag, bus.restore_req, bus.restore_tag,
           bus.redirect_valid, bus.redirect_pc, bus.ckpt_free_valid, bus.ckpt_free_tag,
           bus.frontend_stall, bus.recover_err};
    exp = {fv, ft, rq, rt, rv, rp, cv, ct, st, er};
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic exp_idle(input string tag);
    expect_out(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, err_exp);
  endtask
  task automatic exp_flush(input string tag, input logic [4:0] t);
    expect_out(tag, 1, t, 0, 0, 0, 0, 0, 0, 1, err_exp);
  endtask
  task automatic exp_req(input string tag, input logic [4:0] t);
    expect_out(tag, 0, 0, 1, t, 0, 0, 0, 0, 1, err_exp);
  endtask
  task automatic exp_redir(input string tag, input logic [31:0] pc);
    expect_out(tag, 0, 0, 0, 0, 1, pc, 0, 0, 1, err_exp);
  endtask

  initial begin
    reset = 1'b1;
    bus.rob_head = 5'd0;
    clr();
    tick();
    tick();
    exp_idle("reset_hold");
    reset = 1'b0;
    tick();
    exp_idle("reset_release");

    // Basic recovery: tag 5, pc 0x100, ack two cycles after req rises
    mispredict(5'd5, 32'h100);
    tick();                              // cycle N+1
    clr();
    exp_flush("basic_flush", 5'd5);
    tick();
    exp_req("basic_req_n2", 5'd5);
    tick();
    exp_req("basic_req_n3", 5'd5);
    tick();
    exp_req("basic_req_n4", 5'd5);
    bus.restore_ack = 1'b1;
    tick();
    bus.restore_ack = 1'b0;
    exp_redir("basic_redirect", 32'h100);
    tick();
    exp_idle("basic_idle");

    // Hit in IDLE
    hit(5'd7);
    tick();
    clr();
    expect_out("hit_idle_free", 0, 0, 0, 0, 0, 0, 1, 5'd7, 0, err_exp);
    tick();
    exp_idle("hit_idle_after");

    // Older override with wrapped head
    bus.rob_head = 5'd30;
    mispredict(5'd3, 32'h300);
    tick();
    clr();
    exp_flush("ovr_flush3", 5'd3);
    tick();
    exp_req("ovr_req3", 5'd3);
    mispredict(5'd31, 32'h200);          // age 1 < age 5
    tick();
    clr();
    exp_flush("ovr_reflush31", 5'd31);
    tick();
    exp_req("ovr_req31", 5'd31);
    mispredict(5'd4, 32'h444);           // age 6: dropped
    tick();
    clr();
    exp_req("ovr_drop4", 5'd31);
    hit(5'd30);                          // age 0: older, freed
    tick();
    clr();
    expect_out("ovr_hit_older", 0, 0, 1, 5'd31, 0, 0, 1, 5'd30, 1, err_exp);
    hit(5'd2);                           // age 4: younger, dropped
    tick();
    clr();
    exp_req("ovr_hit_younger", 5'd31);
    bus.restore_ack = 1'b1;
    tick();
    clr();
    exp_redir("ovr_redirect", 32'h200);
    tick();
    exp_idle("ovr_idle");

    // Older mispredict on the edge that would enter REDIRECT
    bus.rob_head = 5'd0;
    mispredict(5'd10, 32'h400);
    tick();
    clr();
    exp_flush("rd_flush10", 5'd10);
    tick();
    exp_req("rd_req10", 5'd10);
    mispredict(5'd6, 32'h500);
    bus.restore_ack = 1'b1;
    tick();
    clr();
    exp_flush("rd_flush6_no_redirect", 5'd6);
    tick();
    exp_req("rd_req6", 5'd6);
    bus.restore_ack = 1'b1;
    tick();
    clr();
    exp_redir("rd_redirect500", 32'h500);
    // Older mispredict while in REDIRECT, then again while in FLUSH
    mispredict(5'd2, 32'h600);
    tick();
    clr();
    exp_flush("rd_flush2", 5'd2);
    mispredict(5'd1, 32'h700);
    tick();
    clr();
    exp_flush("rd_flush1_b2b", 5'd1);
    tick();
    exp_req("rd_req1", 5'd1);
    bus.restore_ack = 1'b1;
    tick();
    clr();
    exp_redir("rd_redirect700", 32'h700);
    tick();
    exp_idle("rd_idle");

    // Reset mid-RESTORE
    mispredict(5'd9, 32'h800);
    tick();
    clr();
    exp_flush("rst_flush9", 5'd9);
    tick();
    exp_req("rst_req9", 5'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_idle("rst_cleared");
    bus.restore_ack = 1'b1;
    tick();
    clr();
    exp_idle("rst_no_redirect");
    tick();
    exp_idle("rst_idle");

`ifdef BRCTL_RESTORE_TIMEOUT_EN
    // Watchdog: no ack, redirect at N+18, sticky error
    mispredict(5'd12, 32'h900);
    tick();
    clr();
    exp_flush("to_flush", 5'd12);
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_req("to_req_wait", 5'd12);
    end
    tick();
    err_exp = 1'b1;
    exp_redir("to_redirect", 32'h900);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_idle("to_err_sticky");
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    err_exp = 1'b0;
    exp_idle("to_err_reset");
`else
    // Without the watchdog, RESTORE waits for ack indefinitely
    mispredict(5'd12, 32'h900);
    tick();
    clr();
    exp_flush("wait_flush", 5'd12);
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_req("wait_req", 5'd12);
    end
    bus.restore_ack = 1'b1;
    tick();
    clr();
    exp_redir("wait_redirect", 32'h900);
    tick();
    exp_idle("wait_idle");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
